// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that shares one data-memory port between
// the core load/store path (port 0) and a debug/loader master (port 1).
// One transaction is in flight at a time. Reads hold mem_rd for RD_LAT
// cycles and capture the returned word in the last of them. Each
// transaction ends with a one-cycle done pulse to its owner.
module dmem_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_done,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_done,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

   // RD_LAT is 1..4, so the last latency count always fits in two bits
   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   state_t            state_q, state_d;
   logic              last_q, last_d;       // port granted most recently: 0 core, 1 dbg
   logic              win_q, win_d;         // owner of the transaction in flight
   logic [1:0]        lat_cnt_q, lat_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              any_req;
   logic              pick_dbg;
   logic              sel_we;

   // Round-robin pick: a lone requester wins, a tie goes to the port not granted last
   always_comb begin
      any_req  = core_req | dbg_req;
      pick_dbg = dbg_req & (~core_req | ~last_q);
      sel_we   = pick_dbg ? dbg_we : core_we;
   end

   // Next-state, capture and strobe decode for the transaction sequencer
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      win_d        = win_q;
      lat_cnt_d    = lat_cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      core_rdata_d = core_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      core_gnt     = 1'b0;
      dbg_gnt      = 1'b0;
      core_done    = 1'b0;
      dbg_done     = 1'b0;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      unique case (state_q)
         IDLE: begin
            // a grant offered while reset is held would be discarded, so none is shown
            if (any_req && reset) begin
               core_gnt  = ~pick_dbg;
               dbg_gnt   = pick_dbg;
               win_d     = pick_dbg;
               last_d    = pick_dbg;
               addr_d    = pick_dbg ? dbg_addr : core_addr;
               wdata_d   = pick_dbg ? dbg_wdata : core_wdata;
               lat_cnt_d = '0;
               state_d   = sel_we ? WR : RD;
            end
         end
         WR: begin
            mem_wr  = 1'b1;
            state_d = RESP;
         end
         RD: begin
            mem_rd = 1'b1;
            if (lat_cnt_q == LAT_LAST) begin
               if (win_q) begin
                  dbg_rdata_d = mem_rdata;
               end else begin
                  core_rdata_d = mem_rdata;
               end
               state_d = RESP;
            end else begin
               lat_cnt_d = 2'(lat_cnt_q + 2'd1);
            end
         end
         RESP: begin
            core_done = ~win_q;
            dbg_done  = win_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and capture registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_q       <= 1'b1;
         win_q        <= 1'b0;
         lat_cnt_q    <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         win_q        <= win_d;
         lat_cnt_q    <= lat_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         core_rdata_q <= core_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

   // Registered views and the combinational core stall
   always_comb begin
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      core_rdata = core_rdata_q;
      dbg_rdata  = dbg_rdata_q;
      busy       = (state_q != IDLE);
      core_stall = core_req & ~core_done;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written
// multi-cycle sequences, and a randomized run checked against a
// transaction-level reference model.
module tb_dmem_arbiter;

   localparam int DW     = 32;
   localparam int AW     = 9;
   localparam int RD_LAT = 2;
   localparam logic [31:0] POISON = 32'hBADC_0DE5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          core_req, core_we, core_gnt, core_done, core_stall;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata, core_rdata;
   logic          dbg_req, dbg_we, dbg_gnt, dbg_done;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata, dbg_rdata;
   logic          mem_rd, mem_wr, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(rst_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_done(core_done), .core_rdata(core_rdata), .core_stall(core_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int a);
      return 32'h1234_0000 ^ 32'(a * 32'h0101_0007);
   endfunction

   // Memory model: data only valid in the final cycle of an RD_LAT-long read
   logic [DW-1:0] mem [0:511];
   bit mem_ready = 1'b0;
   int rd_cnt = 0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 512; i++) mem[i] <= pat(i);
         mem_ready <= 1'b1;
      end else if (mem_wr) begin
         mem[mem_addr] <= mem_wdata;
      end
      rd_cnt <= mem_rd ? rd_cnt + 1 : 0;
   end
   assign mem_rdata = (mem_rd && rd_cnt == RD_LAT - 1) ? mem[mem_addr] : POISON;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic cr, input logic cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input logic dr, input logic dw,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd);
      @(negedge clk);
      rst_n = rst; core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
      dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
      #1;
   endtask

   // flags = {core_gnt, dbg_gnt, core_done, dbg_done, mem_rd, mem_wr, busy, core_stall}
   typedef struct {
      logic          rst;
      logic          cr, cw;
      logic [AW-1:0] ca;
      logic [DW-1:0] cd;
      logic          dr, dw;
      logic [AW-1:0] da;
      logic [DW-1:0] dd;
      logic          chk;
      logic [7:0]    flags;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata, e_crd, e_drd;
   } vec_t;

   localparam int NV = 14;
   vec_t v [NV];

   int ci, di, ngr, ndn;
   logic own_q [$];
   logic [AW-1:0] adr_q [$];
   logic own;
   logic [AW-1:0] oadr;

   // randomized-phase state
   logic [DW-1:0] ref_mem [0:511];
   logic [DW-1:0] rdm [2];
   logic m_last, act, a_w, a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata, a_data;
   int a_start, a_done;
   logic c_pend, c_we, d_pend, d_we;
   logic [AW-1:0] c_addr, d_addr;
   logic [DW-1:0] c_wd, d_wd;
   logic e_cg, e_dg, e_cd, e_dd, e_rd, e_wr, e_busy, e_stall;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;

      // ---- directed vector table: reset, core write, dbg write, core read ----
      v[0]  = '{0, 0,0,9'h000,32'h0,        0,0,9'h000,32'h0,        0, 8'b0000_0000, 9'h000, 32'h0,        32'h0,        32'h0};
      v[1]  = '{0, 0,0,9'h000,32'h0,        0,0,9'h000,32'h0,        1, 8'b0000_0000, 9'h000, 32'h0,        32'h0,        32'h0};
      v[2]  = '{1, 0,0,9'h000,32'h0,        0,0,9'h000,32'h0,        1, 8'b0000_0000, 9'h000, 32'h0,        32'h0,        32'h0};
      v[3]  = '{1, 1,1,9'h010,32'hDEADBEEF, 1,1,9'h020,32'h11111111, 1, 8'b1000_0001, 9'h000, 32'h0,        32'h0,        32'h0};
      v[4]  = '{1, 1,1,9'h010,32'hDEADBEEF, 1,1,9'h020,32'h11111111, 1, 8'b0000_0111, 9'h010, 32'hDEADBEEF, 32'h0,        32'h0};
      v[5]  = '{1, 1,1,9'h010,32'hDEADBEEF, 1,1,9'h020,32'h11111111, 1, 8'b0010_0010, 9'h000, 32'h0,        32'h0,        32'h0};
      v[6]  = '{1, 0,0,9'h000,32'h0,        1,1,9'h020,32'h11111111, 1, 8'b0100_0000, 9'h000, 32'h0,        32'h0,        32'h0};
      v[7]  = '{1, 0,0,9'h000,32'h0,        1,1,9'h020,32'h11111111, 1, 8'b0000_0110, 9'h020, 32'h11111111, 32'h0,        32'h0};
      v[8]  = '{1, 0,0,9'h000,32'h0,        1,1,9'h020,32'h11111111, 1, 8'b0001_0010, 9'h000, 32'h0,        32'h0,        32'h0};
      v[9]  = '{1, 1,0,9'h010,32'h0,        0,0,9'h000,32'h0,        1, 8'b1000_0001, 9'h000, 32'h0,        32'h0,        32'h0};
      v[10] = '{1, 1,0,9'h010,32'h0,        0,0,9'h000,32'h0,        1, 8'b0000_1011, 9'h010, 32'h0,        32'h0,        32'h0};
      v[11] = '{1, 1,0,9'h010,32'h0,        0,0,9'h000,32'h0,        1, 8'b0000_1011, 9'h010, 32'h0,        32'h0,        32'h0};
      v[12] = '{1, 1,0,9'h010,32'h0,        0,0,9'h000,32'h0,        1, 8'b0010_0010, 9'h000, 32'h0,        32'hDEADBEEF, 32'h0};
      v[13] = '{1, 0,0,9'h000,32'h0,        0,0,9'h000,32'h0,        1, 8'b0000_0000, 9'h000, 32'h0,        32'hDEADBEEF, 32'h0};

      for (int i = 0; i < NV; i++) begin
         drive(v[i].rst, v[i].cr, v[i].cw, v[i].ca, v[i].cd, v[i].dr, v[i].dw, v[i].da, v[i].dd);
         if (v[i].chk) begin
            chk($sformatf("vec%0d flags", i),
                32'({core_gnt, dbg_gnt, core_done, dbg_done, mem_rd, mem_wr, busy, core_stall}),
                32'(v[i].flags));
            if (v[i].flags[3] | v[i].flags[2])
               chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(v[i].e_addr));
            if (v[i].flags[2])
               chk($sformatf("vec%0d mem_wdata", i), mem_wdata, v[i].e_wdata);
            chk($sformatf("vec%0d core_rdata", i), core_rdata, v[i].e_crd);
            chk($sformatf("vec%0d dbg_rdata", i), dbg_rdata, v[i].e_drd);
         end
      end

      // ---- both ports read continuously: strict alternation starting with core ----
      drive(0, 0,0,'0,'0, 0,0,'0,'0);
      drive(0, 0,0,'0,'0, 0,0,'0,'0);
      ci = 0; di = 0; ngr = 0; ndn = 0;
      for (int cyc = 0; cyc < 80 && ndn < 6; cyc++) begin
         drive(1, 1,0,9'(9'h100 + ci),'0, 1,0,9'(9'h180 + di),'0);
         chk("t4 one-hot strobes", 32'(mem_rd & mem_wr), 32'd0);
         if (core_done | dbg_done) begin
            if (own_q.size() == 0) begin
               chk("t4 spurious done", 32'd1, 32'd0);
            end else begin
               own  = own_q.pop_front();
               oadr = adr_q.pop_front();
               chk("t4 done owner", 32'({core_done, dbg_done}), own ? 32'b01 : 32'b10);
               chk("t4 rdata", own ? dbg_rdata : core_rdata, pat(int'(oadr)));
            end
            ndn++;
         end
         if (core_gnt | dbg_gnt) begin
            chk("t4 grant order", 32'({core_gnt, dbg_gnt}), (ngr % 2 == 0) ? 32'b10 : 32'b01);
            own_q.push_back(dbg_gnt);
            adr_q.push_back(dbg_gnt ? 9'(9'h180 + di) : 9'(9'h100 + ci));
            if (dbg_gnt) di++; else ci++;
            ngr++;
         end
      end
      chk("t4 completions", 32'(ndn), 32'd6);

      // ---- dbg drops req right after grant; held core req granted after dbg_done ----
      drive(1, 0,0,'0,'0, 0,0,'0,'0);
      drive(1, 0,0,'0,'0, 1,1,9'h1F0,32'hCAFEF00D);
      chk("t5 dbg gnt", 32'({core_gnt, dbg_gnt}), 32'b01);
      drive(1, 1,0,9'h1F0,'0, 0,0,'0,'0);
      chk("t5 write strobe", 32'({mem_rd, mem_wr, core_gnt, core_stall}), 32'b0101);
      chk("t5 write addr", 32'(mem_addr), 32'h1F0);
      chk("t5 write data", mem_wdata, 32'hCAFEF00D);
      drive(1, 1,0,9'h1F0,'0, 0,0,'0,'0);
      chk("t5 dbg done", 32'({dbg_done, core_done, core_gnt}), 32'b100);
      drive(1, 1,0,9'h1F0,'0, 0,0,'0,'0);
      chk("t5 core gnt after done", 32'({core_gnt, dbg_gnt}), 32'b10);
      drive(1, 1,0,9'h1F0,'0, 0,0,'0,'0);
      drive(1, 1,0,9'h1F0,'0, 0,0,'0,'0);
      drive(1, 1,0,9'h1F0,'0, 0,0,'0,'0);
      chk("t5 core read done", 32'({core_done, dbg_done, core_stall}), 32'b100);
      chk("t5 core rdata", core_rdata, 32'hCAFEF00D);

      // ---- reset during the second read cycle aborts the read ----
      drive(1, 1,0,9'h055,'0, 0,0,'0,'0);
      chk("t6 core gnt", 32'(core_gnt), 32'd1);
      drive(1, 1,0,9'h055,'0, 1,1,9'h066,32'h66);
      chk("t6 rd lat0", 32'({mem_rd, busy}), 32'b11);
      drive(0, 1,0,9'h055,'0, 1,1,9'h066,32'h66);
      chk("t6 rd lat1", 32'({mem_rd, busy}), 32'b11);
      drive(1, 0,0,'0,'0, 1,1,9'h066,32'h66);
      chk("t6 aborted", 32'({mem_rd, busy, core_done, dbg_done}), 32'b0000);
      chk("t6 rdata cleared", core_rdata, 32'h0);
      chk("t6 dbg first when core idle", 32'({core_gnt, dbg_gnt}), 32'b01);
      drive(1, 0,0,'0,'0, 0,0,'0,'0);
      chk("t6 dbg write", 32'({mem_wr, core_done}), 32'b10);
      drive(1, 0,0,'0,'0, 0,0,'0,'0);
      chk("t6 dbg done only", 32'({core_done, dbg_done}), 32'b01);
      drive(0, 1,0,9'h001,'0, 1,0,9'h002,'0);
      drive(1, 1,0,9'h001,'0, 1,0,9'h002,'0);
      chk("t6 core wins tie after reset", 32'({core_gnt, dbg_gnt}), 32'b10);

      // ---- randomized traffic against a transaction-level model ----
      drive(0, 0,0,'0,'0, 0,0,'0,'0);
      drive(0, 0,0,'0,'0, 0,0,'0,'0);
      for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];
      rdm[0] = '0; rdm[1] = '0; m_last = 1'b1; act = 1'b0;
      a_w = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_data = '0; a_start = 0; a_done = 0;
      c_pend = 0; d_pend = 0; c_we = 0; d_we = 0; c_addr = '0; d_addr = '0; c_wd = '0; d_wd = '0;
      for (int k = 0; k < 2000; k++) begin
         if (!c_pend && $urandom_range(0, 2) != 0) begin
            c_pend = 1; c_we = 1'($urandom_range(0, 1));
            c_addr = 9'($urandom_range(0, 31)); c_wd = $urandom;
         end
         if (!d_pend && $urandom_range(0, 2) != 0) begin
            d_pend = 1; d_we = 1'($urandom_range(0, 1));
            d_addr = 9'($urandom_range(0, 31)); d_wd = $urandom;
         end
         drive(1, c_pend, c_we, c_addr, c_wd, d_pend, d_we, d_addr, d_wd);

         e_cg = 0; e_dg = 0; e_cd = 0; e_dd = 0; e_rd = 0; e_wr = 0; e_busy = 0;
         if (act) begin
            e_busy = (k > a_start);
            if (a_we) e_wr = (k == a_start + 1);
            else      e_rd = (k > a_start) && (k <= a_start + RD_LAT);
            if (k == a_done) begin
               if (a_w) e_dd = 1; else e_cd = 1;
               if (!a_we) rdm[a_w] = a_data;
               act = 0;
            end
         end else if (c_pend || d_pend) begin
            a_w     = (c_pend && d_pend) ? ~m_last : d_pend;
            m_last  = a_w;
            act     = 1;
            a_start = k;
            a_we    = a_w ? d_we : c_we;
            a_addr  = a_w ? d_addr : c_addr;
            a_wdata = a_w ? d_wd : c_wd;
            a_done  = k + (a_we ? 2 : RD_LAT + 1);
            if (a_we) ref_mem[a_addr] = a_wdata;
            else      a_data = ref_mem[a_addr];
            if (a_w) e_dg = 1; else e_cg = 1;
         end
         e_stall = c_pend & ~e_cd;

         chk("rnd gnt", 32'({core_gnt, dbg_gnt}), 32'({e_cg, e_dg}));
         chk("rnd done", 32'({core_done, dbg_done}), 32'({e_cd, e_dd}));
         chk("rnd strobes", 32'({mem_rd, mem_wr}), 32'({e_rd, e_wr}));
         chk("rnd busy", 32'(busy), 32'(e_busy));
         chk("rnd stall", 32'(core_stall), 32'(e_stall));
         chk("rnd core_rdata", core_rdata, rdm[0]);
         chk("rnd dbg_rdata", dbg_rdata, rdm[1]);
         if (e_rd | e_wr) chk("rnd mem_addr", 32'(mem_addr), 32'(a_addr));
         if (e_wr) chk("rnd mem_wdata", mem_wdata, a_wdata);

         if (core_gnt) c_pend = 0;
         if (dbg_gnt)  d_pend = 0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
